// File: rtl/xpt_itable_sequencer_pkg.sv
// Shared constants for the XPT/ITABLE sequencer and the instruction-group decoders.
package xpt_itable_sequencer_pkg;

    localparam int unsigned XPT_W    = 4;
    localparam int unsigned ITABLE_W = 8;

    localparam logic [ITABLE_W-1:0] ITABLE_RESET_DEFAULT = 8'h00;

    // Named phases the decoders key their end-of-instruction strobes on
    localparam logic [XPT_W-1:0] XPT_PH3  = 4'd3;
    localparam logic [XPT_W-1:0] XPT_PH8  = 4'd8;
    localparam logic [XPT_W-1:0] XPT_PH9  = 4'd9;
    localparam logic [XPT_W-1:0] XPT_PH10 = 4'd10;

endpackage

// File: rtl/xpt_phase_counter.sv
// XPT phase register with registered complement; clear beats increment, reset beats both.
module xpt_phase_counter
    import xpt_itable_sequencer_pkg::*;
#(
    parameter int unsigned Width = XPT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [Width-1:0] xpt_o,
    output logic [Width-1:0] not_xpt_o
);

    logic [Width-1:0] xpt_q, xpt_d;
    logic [Width-1:0] not_xpt_q;

    always_comb begin
        xpt_d = xpt_q;
        if (clear_i) begin
            xpt_d = '0;
        end else if (inc_i) begin
            xpt_d = xpt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xpt_q     <= '0;
            not_xpt_q <= '1;
        end else begin
            xpt_q     <= xpt_d;
            not_xpt_q <= ~xpt_d;
        end
    end

    assign xpt_o     = xpt_q;
    assign not_xpt_o = not_xpt_q;

endmodule

// File: rtl/xpt_itable_sequencer.sv
// FETCH/EXEC sequencer driving XPT, ITABLE and enable into the decoder tree.
// Define XPT_WATCHDOG_EN to force a return to M1 and set seq_fault on a phase overrun.
module xpt_itable_sequencer
    import xpt_itable_sequencer_pkg::*;
#(
    parameter int unsigned                XPT_WIDTH    = XPT_W,
    parameter int unsigned                ITABLE_WIDTH = ITABLE_W,
    parameter logic [ITABLE_WIDTH-1:0]    ITABLE_RESET = ITABLE_RESET_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    fetch_req,
    input  logic                    fetch_valid,
    input  logic [ITABLE_WIDTH-1:0] fetch_data,
    input  logic                    stall,
    input  logic                    PR_Reset_XPT,
    input  logic                    P2_Reset_ITABLE,
    input  logic                    P2_Set_CM1,
    output logic                    enable,
    output logic [XPT_WIDTH-1:0]    XPT,
    output logic [XPT_WIDTH-1:0]    notXPT,
    output logic [ITABLE_WIDTH-1:0] ITABLE,
    output logic [ITABLE_WIDTH-1:0] notITABLE,
    output logic                    seq_fault
);

    localparam logic ST_FETCH = 1'b1;  // CM1 = 1
    localparam logic ST_EXEC  = 1'b0;

    logic                    cm1_q, cm1_d;
    logic [ITABLE_WIDTH-1:0] itable_q, itable_d;
    logic [ITABLE_WIDTH-1:0] not_itable_q;
    logic                    xpt_clr, xpt_inc;
    logic [XPT_WIDTH-1:0]    xpt;
    logic                    fault_q, fault_d;

    always_comb begin
        cm1_d    = cm1_q;
        itable_d = itable_q;
        xpt_clr  = 1'b0;
        xpt_inc  = 1'b0;
        fault_d  = fault_q;
        if (cm1_q == ST_FETCH) begin
            if (fetch_valid) begin
                itable_d = fetch_data;
                xpt_clr  = 1'b1;
                cm1_d    = ST_EXEC;
            end
        end else begin
            xpt_inc = ~stall;
            xpt_clr = PR_Reset_XPT;
            if (P2_Reset_ITABLE) itable_d = ITABLE_RESET;
            if (P2_Set_CM1)      cm1_d    = ST_FETCH;
`ifdef XPT_WATCHDOG_EN
            // Overrun: no decoder ended the instruction before the last phase
            if ((&xpt) && !stall && !PR_Reset_XPT) begin
                cm1_d    = ST_FETCH;
                xpt_clr  = 1'b1;
                itable_d = ITABLE_RESET;
                fault_d  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cm1_q        <= ST_FETCH;
            itable_q     <= ITABLE_RESET;
            not_itable_q <= ~ITABLE_RESET;
            fault_q      <= 1'b0;
        end else begin
            cm1_q        <= cm1_d;
            itable_q     <= itable_d;
            not_itable_q <= ~itable_d;
            fault_q      <= fault_d;
        end
    end

    xpt_phase_counter #(
        .Width (XPT_WIDTH)
    ) u_phase (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (xpt_clr),
        .inc_i     (xpt_inc),
        .xpt_o     (xpt),
        .not_xpt_o (notXPT)
    );

    assign XPT       = xpt;
    assign fetch_req = cm1_q;
    assign enable    = ~cm1_q;
    assign ITABLE    = itable_q;
    assign notITABLE = not_itable_q;
`ifdef XPT_WATCHDOG_EN
    assign seq_fault = fault_q;
`else
    assign seq_fault = 1'b0;
`endif

endmodule

// File: tb/tb_xpt_itable_sequencer.sv
// Directed bench for xpt_itable_sequencer; watchdog expectations follow XPT_WATCHDOG_EN.
module tb_xpt_itable_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_req;
    logic       fetch_valid;
    logic [7:0] fetch_data;
    logic       stall;
    logic       PR_Reset_XPT, P2_Reset_ITABLE, P2_Set_CM1;
    logic       enable;
    logic [3:0] XPT, notXPT;
    logic [7:0] ITABLE, notITABLE;
    logic       seq_fault;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    xpt_itable_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .fetch_valid     (fetch_valid),
        .fetch_data      (fetch_data),
        .stall           (stall),
        .PR_Reset_XPT    (PR_Reset_XPT),
        .P2_Reset_ITABLE (P2_Reset_ITABLE),
        .P2_Set_CM1      (P2_Set_CM1),
        .enable          (enable),
        .XPT             (XPT),
        .notXPT          (notXPT),
        .ITABLE          (ITABLE),
        .notITABLE       (notITABLE),
        .seq_fault       (seq_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge, sample 1ns later, and check the complement invariant
    task automatic tick();
        @(posedge clk);
        #1;
        chk("inv_xpt", 32'(XPT ^ notXPT), 32'hF);
        chk("inv_itable", 32'(ITABLE ^ notITABLE), 32'hFF);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobes(input logic v);
        PR_Reset_XPT    = v;
        P2_Reset_ITABLE = v;
        P2_Set_CM1      = v;
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_data = 8'h00; stall = 1'b0;
        strobes(1'b0);
        ticks(2);
        reset = 1'b0;
        tick();
        chk("rst_fetch_req", 32'(fetch_req), 32'd1);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_xpt", 32'(XPT), 32'd0);
        chk("rst_notxpt", 32'(notXPT), 32'hF);
        chk("rst_itable", 32'(ITABLE), 32'h00);
        chk("rst_notitable", 32'(notITABLE), 32'hFF);
        chk("rst_fault", 32'(seq_fault), 32'd0);

        // Stall and strobes are ignored in FETCH
        stall = 1'b1; strobes(1'b1);
        tick();
        chk("fetch_idle_req", 32'(fetch_req), 32'd1);
        chk("fetch_idle_xpt", 32'(XPT), 32'd0);
        stall = 1'b0; strobes(1'b0);

        fetch_valid = 1'b1; fetch_data = 8'hD8;
        tick();
        fetch_valid = 1'b0; fetch_data = 8'h33;
        chk("fetch_itable", 32'(ITABLE), 32'hD8);
        chk("fetch_notitable", 32'(notITABLE), 32'h27);
        chk("fetch_enable", 32'(enable), 32'd1);
        chk("fetch_req_low", 32'(fetch_req), 32'd0);
        chk("fetch_xpt", 32'(XPT), 32'd0);
        tick(); chk("xpt1", 32'(XPT), 32'd1);
        tick(); chk("xpt2", 32'(XPT), 32'd2);
        tick(); chk("xpt3", 32'(XPT), 32'd3);

        // fetch_valid ignored in EXEC
        stall = 1'b1; fetch_valid = 1'b1;
        tick(); chk("stall_a", 32'(XPT), 32'd3);
        tick(); chk("stall_b", 32'(XPT), 32'd3);
        chk("exec_ignores_fetch", 32'(ITABLE), 32'hD8);
        stall = 1'b0; fetch_valid = 1'b0;
        tick(); chk("unstall", 32'(XPT), 32'd4);
        ticks(6); chk("xpt10", 32'(XPT), 32'd10);

        strobes(1'b1);
        tick();
        strobes(1'b0);
        chk("end_xpt", 32'(XPT), 32'd0);
        chk("end_itable", 32'(ITABLE), 32'h00);
        chk("end_req", 32'(fetch_req), 32'd1);
        chk("end_enable", 32'(enable), 32'd0);

        fetch_valid = 1'b1; fetch_data = 8'hC9;
        tick();
        fetch_valid = 1'b0;
        chk("b2b_itable", 32'(ITABLE), 32'hC9);
        chk("b2b_enable", 32'(enable), 32'd1);

        // Same end-of-instruction with stall held
        ticks(10); chk("xpt10_b", 32'(XPT), 32'd10);
        stall = 1'b1; strobes(1'b1);
        tick();
        strobes(1'b0);
        chk("end_stall_xpt", 32'(XPT), 32'd0);
        chk("end_stall_itable", 32'(ITABLE), 32'h00);
        chk("end_stall_req", 32'(fetch_req), 32'd1);
        fetch_valid = 1'b1; fetch_data = 8'hC9;
        tick();
        fetch_valid = 1'b0; stall = 1'b0;
        chk("b2b_stall_itable", 32'(ITABLE), 32'hC9);
        chk("b2b_stall_xpt", 32'(XPT), 32'd0);

        // Reset mid-instruction wins over strobes and fetch data
        ticks(5); chk("xpt5", 32'(XPT), 32'd5);
        reset = 1'b1; P2_Set_CM1 = 1'b1; fetch_valid = 1'b1; fetch_data = 8'hAA;
        tick();
        reset = 1'b0; P2_Set_CM1 = 1'b0; fetch_valid = 1'b0;
        chk("mid_rst_xpt", 32'(XPT), 32'd0);
        chk("mid_rst_itable", 32'(ITABLE), 32'h00);
        chk("mid_rst_req", 32'(fetch_req), 32'd1);
        chk("mid_rst_enable", 32'(enable), 32'd0);
        chk("mid_rst_fault", 32'(seq_fault), 32'd0);

        fetch_valid = 1'b1; fetch_data = 8'h5A;
        tick();
        fetch_valid = 1'b0;
        ticks(15); chk("xpt15", 32'(XPT), 32'd15);
        chk("xpt15_enable", 32'(enable), 32'd1);
        tick();
`ifdef XPT_WATCHDOG_EN
        chk("wd_fault", 32'(seq_fault), 32'd1);
        chk("wd_req", 32'(fetch_req), 32'd1);
        chk("wd_xpt", 32'(XPT), 32'd0);
        chk("wd_itable", 32'(ITABLE), 32'h00);
        ticks(2);
        chk("wd_sticky", 32'(seq_fault), 32'd1);
`else
        chk("wrap_xpt", 32'(XPT), 32'd0);
        chk("wrap_enable", 32'(enable), 32'd1);
        chk("wrap_fault", 32'(seq_fault), 32'd0);
        chk("wrap_itable", 32'(ITABLE), 32'h5A);
        tick();
        chk("wrap_xpt1", 32'(XPT), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
